// File: rtl/vga_frame_capture_pkg.sv
// Shared constants, lock-FSM encoding and pixel payload for the VGA frame-capture path.
package vga_frame_capture_pkg;

    localparam int unsigned COLOR_WIDTH = 4;

    localparam int unsigned DEF_WIDTH   = 640;
    localparam int unsigned DEF_HEIGHT  = 480;
    localparam int unsigned DEF_RS      = 5;

    localparam int unsigned DEF_H_SYNC  = 96;
    localparam int unsigned DEF_H_BACK  = 48;
    localparam int unsigned DEF_H_TOTAL = 800;
    localparam int unsigned DEF_V_SYNC  = 2;
    localparam int unsigned DEF_V_BACK  = 33;
    localparam int unsigned DEF_V_TOTAL = 525;

    localparam int unsigned DEF_LOCK_FRAMES = 2;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned HC_W   = 11;
    localparam int unsigned VC_W   = 10;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lockState_t;

    typedef struct packed {
        logic [COLOR_WIDTH-1:0] b;
        logic [COLOR_WIDTH-1:0] g;
        logic [COLOR_WIDTH-1:0] r;
    } pixel_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned phaseWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_tracker.sv
// Recovers h/v position from sync edges, checks line/frame lengths and runs the lock FSM.
// All outputs are aligned with the registered hCnt/vCnt sample.
module vga_timing_tracker
    import vga_frame_capture_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned HEIGHT      = DEF_HEIGHT,
    parameter int unsigned RS          = DEF_RS,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BACK      = DEF_H_BACK,
    parameter int unsigned H_TOTAL     = DEF_H_TOTAL,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter int unsigned V_TOTAL     = DEF_V_TOTAL,
    parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES,
    localparam int unsigned PH_W       = phaseWidth(RS)
) (
    input  logic            iVGA_CLK,
    input  logic            iRST_n,
    input  logic            iHS,
    input  logic            iVS,
    output logic            activeC,
    output logic [PH_W-1:0] xs,
    output logic [PH_W-1:0] ys,
    output logic            vsFall,
    output logic            syncErr,
    output logic            locked
);

    localparam int unsigned H_ACT0 = H_SYNC + H_BACK;
    localparam int unsigned H_ACT1 = H_ACT0 + WIDTH;
    localparam int unsigned V_ACT0 = V_SYNC + V_BACK;
    localparam int unsigned V_ACT1 = V_ACT0 + HEIGHT;
    localparam int unsigned GC_W   = phaseWidth(LOCK_FRAMES + 1);

    logic            hsS0, hsS1, vsS0, vsS1;
    logic            hsFallC, vsFallC, hActC, vActC;
    logic            lineBadC, frameBadC, badC, syncErrNext;
    logic [HC_W-1:0] hCnt;
    logic [VC_W-1:0] vCnt;
    logic            skipLine;
    lockState_t      state, stateNext;
    logic [GC_W-1:0] goodCnt, goodCntNext;

    assign hsFallC   = hsS1 & ~hsS0;
    assign vsFallC   = vsS1 & ~vsS0;
    assign hActC     = (hCnt >= HC_W'(H_ACT0)) && (hCnt < HC_W'(H_ACT1));
    assign vActC     = (vCnt >= VC_W'(V_ACT0)) && (vCnt < VC_W'(V_ACT1));
    assign activeC   = hActC & vActC;
    assign lineBadC  = hsFallC & ~skipLine & (hCnt != HC_W'(H_TOTAL - 1));
    assign frameBadC = vsFallC & (vCnt != VC_W'(V_TOTAL - 1));
    assign badC      = lineBadC | frameBadC;
    assign locked    = (state == LOCKED);

    // Sync input stage s0 and previous-sample stage s1 for edge detection.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hsS0 <= 1'b0;
            hsS1 <= 1'b0;
            vsS0 <= 1'b0;
            vsS1 <= 1'b0;
        end else begin
            hsS0 <= iHS;
            hsS1 <= hsS0;
            vsS0 <= iVS;
            vsS1 <= vsS0;
        end
    end

    // Saturating position counters; a VS fall wins over a coincident HS fall.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hCnt <= '0;
            vCnt <= '0;
        end else begin
            if (hsFallC)           hCnt <= '0;
            else if (hCnt != '1)   hCnt <= hCnt + HC_W'(1);
            if (vsFallC)                      vCnt <= '0;
            else if (hsFallC && vCnt != '1)   vCnt <= vCnt + VC_W'(1);
        end
    end

    // Decimation phases: xs held at 0 outside active pixels, ys at 0 outside active lines.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            xs <= '0;
            ys <= '0;
        end else begin
            if (activeC) xs <= (xs == PH_W'(RS - 1)) ? '0 : xs + PH_W'(1);
            else         xs <= '0;
            if (vsFallC) begin
                ys <= '0;
            end else if (hsFallC) begin
                if (vActC) ys <= (ys == PH_W'(RS - 1)) ? '0 : ys + PH_W'(1);
                else       ys <= '0;
            end
        end
    end

    // Line check is skipped for the first HS fall after reset or after dropping to SEARCH.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n)                                     skipLine <= 1'b1;
        else if (stateNext == SEARCH && state != SEARCH) skipLine <= 1'b1;
        else if (hsFallC)                                skipLine <= 1'b0;
    end

    // Lock FSM state register plus aligned event pulses.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state   <= SEARCH;
            goodCnt <= '0;
            syncErr <= 1'b0;
            vsFall  <= 1'b0;
        end else begin
            state   <= stateNext;
            goodCnt <= goodCntNext;
            syncErr <= syncErrNext;
            vsFall  <= vsFallC;
        end
    end

    // Lock FSM next state: count clean frames in VERIFY, drop to SEARCH on any bad check.
    always_comb begin
        stateNext   = state;
        goodCntNext = goodCnt;
        syncErrNext = 1'b0;
        case (state)
            SEARCH: begin
                if (vsFallC) begin
                    stateNext   = VERIFY;
                    goodCntNext = '0;
                end
            end
            VERIFY: begin
                if (badC) begin
                    stateNext = SEARCH;
                end else if (vsFallC) begin
                    goodCntNext = goodCnt + GC_W'(1);
                    if (goodCnt == GC_W'(LOCK_FRAMES - 1)) stateNext = LOCKED;
                end
            end
            LOCKED: begin
                if (badC) begin
                    stateNext   = SEARCH;
                    syncErrNext = 1'b1;
                end
            end
            default: stateNext = SEARCH;
        endcase
    end

endmodule

// File: rtl/vga_frame_capture.sv
// Captures a decimated copy of the active VGA picture into a frame-buffer write port.
module vga_frame_capture
    import vga_frame_capture_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned HEIGHT      = DEF_HEIGHT,
    parameter int unsigned RS          = DEF_RS,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BACK      = DEF_H_BACK,
    parameter int unsigned H_TOTAL     = DEF_H_TOTAL,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter int unsigned V_TOTAL     = DEF_V_TOTAL,
    parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic                     iVGA_CLK,
    input  logic                     iRST_n,
    input  logic                     iHS,
    input  logic                     iVS,
    input  logic [COLOR_WIDTH-1:0]   iR,
    input  logic [COLOR_WIDTH-1:0]   iG,
    input  logic [COLOR_WIDTH-1:0]   iB,
    output logic [ADDR_W-1:0]        oWADDR,
    output logic [3*COLOR_WIDTH-1:0] oWDATA,
    output logic                     oWE,
    output logic                     oLOCKED,
    output logic                     oFRAME_DONE,
    output logic                     oSYNC_ERR
);

    localparam int unsigned PH_W         = phaseWidth(RS);
    localparam int unsigned FRAME_WRITES = (WIDTH / RS) * (HEIGHT / RS);

    pixel_t            pixS0, pixS1;
    logic              activeC, vsFall, syncErr, locked;
    logic [PH_W-1:0]   xs, ys;
    logic [ADDR_W-1:0] wrPtr;
    logic              wrEnC;

    vga_timing_tracker #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .RS         (RS),
        .H_SYNC     (H_SYNC),
        .H_BACK     (H_BACK),
        .H_TOTAL    (H_TOTAL),
        .V_SYNC     (V_SYNC),
        .V_BACK     (V_BACK),
        .V_TOTAL    (V_TOTAL),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) uTracker (
        .iVGA_CLK(iVGA_CLK),
        .iRST_n  (iRST_n),
        .iHS     (iHS),
        .iVS     (iVS),
        .activeC (activeC),
        .xs      (xs),
        .ys      (ys),
        .vsFall  (vsFall),
        .syncErr (syncErr),
        .locked  (locked)
    );

    assign wrEnC = locked & activeC & (xs == '0) & (ys == '0);

    // Pixel pipeline kept in step with the tracker's sync stages.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pixS0 <= '0;
            pixS1 <= '0;
        end else begin
            pixS0 <= '{b: iB, g: iG, r: iR};
            pixS1 <= pixS0;
        end
    end

    // RAM port, write pointer and status registers; the pointer doubles as the per-frame write count.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oWADDR      <= '0;
            oWDATA      <= '0;
            oWE         <= 1'b0;
            oLOCKED     <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oSYNC_ERR   <= 1'b0;
            wrPtr       <= '0;
        end else begin
            oWE         <= wrEnC;
            oLOCKED     <= locked;
            oSYNC_ERR   <= syncErr;
            oFRAME_DONE <= vsFall & locked & (wrPtr == ADDR_W'(FRAME_WRITES));
            if (vsFall) begin
                wrPtr  <= '0;
                oWADDR <= '0;
            end else if (wrEnC) begin
                oWADDR <= wrPtr;
                oWDATA <= pixS1;
                wrPtr  <= wrPtr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Scoreboard bench for vga_frame_capture using a reduced raster so whole frames stay short.
`timescale 1ns/1ps
module tb_vga_frame_capture;
    import vga_frame_capture_pkg::*;

    localparam int T_WIDTH  = 20;
    localparam int T_HEIGHT = 10;
    localparam int T_RS     = 5;
    localparam int T_HSYNC  = 4;
    localparam int T_HBACK  = 4;
    localparam int T_HTOTAL = 32;
    localparam int T_VSYNC  = 2;
    localparam int T_VBACK  = 2;
    localparam int T_VTOTAL = 16;
    localparam int XD       = T_WIDTH / T_RS;
    localparam int HA0      = T_HSYNC + T_HBACK;
    localparam int VA0      = T_VSYNC + T_VBACK;

    logic        iVGA_CLK = 1'b0;
    logic        iRST_n   = 1'b0;
    logic        iHS      = 1'b1;
    logic        iVS      = 1'b1;
    logic [3:0]  iR = '0, iG = '0, iB = '0;
    logic [19:0] oWADDR;
    logic [11:0] oWDATA;
    logic        oWE, oLOCKED, oFRAME_DONE, oSYNC_ERR;

    int errors  = 0;
    int checks  = 0;
    int doneCnt = 0;
    int errCnt  = 0;

    logic [19:0] expAddr[$];
    logic [11:0] expData[$];
    logic [19:0] popA;
    logic [11:0] popD;

    vga_frame_capture #(
        .WIDTH(T_WIDTH), .HEIGHT(T_HEIGHT), .RS(T_RS),
        .H_SYNC(T_HSYNC), .H_BACK(T_HBACK), .H_TOTAL(T_HTOTAL),
        .V_SYNC(T_VSYNC), .V_BACK(T_VBACK), .V_TOTAL(T_VTOTAL),
        .LOCK_FRAMES(2)
    ) dut (
        .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .iHS(iHS), .iVS(iVS),
        .iR(iR), .iG(iG), .iB(iB),
        .oWADDR(oWADDR), .oWDATA(oWDATA), .oWE(oWE),
        .oLOCKED(oLOCKED), .oFRAME_DONE(oFRAME_DONE), .oSYNC_ERR(oSYNC_ERR)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Mode 0: deterministic gradient; mode 1: only pixel (5,5) lit.
    function automatic logic [11:0] pix(input int mode, input int x, input int y);
        if (mode == 1) return (x == 5 && y == 5) ? 12'hABC : 12'h000;
        return 12'((x * 37 + y * 101 + 7) % 4096);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge iVGA_CLK);
            iHS = 1'b1; iVS = 1'b1;
            iR = '0; iG = '0; iB = '0;
        end
    endtask

    // One frame; expRows decimated rows are pushed as expected writes, rstLine<0 means no reset.
    task automatic send_frame(input int mode, input int lines, input int shortLine,
                              input int expRows, input int rstLine);
        int          len;
        logic        act;
        logic [11:0] p;
        for (int r = 0; r < expRows; r++) begin
            for (int c = 0; c < XD; c++) begin
                expAddr.push_back(20'(c + r * XD));
                expData.push_back(pix(mode, c * T_RS, r * T_RS));
            end
        end
        for (int v = 0; v < lines; v++) begin
            len = (v == shortLine) ? T_HTOTAL - 1 : T_HTOTAL;
            for (int h = 0; h < len; h++) begin
                @(negedge iVGA_CLK);
                iHS = (h < T_HSYNC) ? 1'b0 : 1'b1;
                iVS = (v < T_VSYNC) ? 1'b0 : 1'b1;
                act = (h >= HA0) && (h < HA0 + T_WIDTH) && (v >= VA0) && (v < VA0 + T_HEIGHT);
                p   = act ? pix(mode, h - HA0, v - VA0) : 12'h000;
                iR  = p[3:0]; iG = p[7:4]; iB = p[11:8];
                if (v == rstLine && h == 10) begin
                    iRST_n = 1'b0;
                    #1;
                    chk("rst_mid_locked", oLOCKED, 0);
                    chk("rst_mid_waddr", oWADDR, 0);
                    chk("rst_mid_wdata", oWDATA, 0);
                    chk("rst_mid_we", oWE, 0);
                end
                if (v == rstLine && h == 13) iRST_n = 1'b1;
            end
        end
    endtask

    // Monitor: every write is matched against the scoreboard; pulses are tallied.
    always @(negedge iVGA_CLK) begin
        if (oWE) begin
            chk("we_while_locked", oLOCKED, 1);
            if (expAddr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %03h, none expected", oWADDR, oWDATA);
            end else begin
                popA = expAddr.pop_front();
                popD = expData.pop_front();
                chk("waddr", oWADDR, popA);
                chk("wdata", oWDATA, popD);
            end
        end
        if (oFRAME_DONE) doneCnt++;
        if (oSYNC_ERR) begin
            errCnt++;
            chk("err_drops_lock", oLOCKED, 0);
        end
    end

    initial begin
        iRST_n = 1'b0;
        repeat (3) @(negedge iVGA_CLK);
        chk("rst_waddr", oWADDR, 0);
        chk("rst_wdata", oWDATA, 0);
        chk("rst_we", oWE, 0);
        chk("rst_locked", oLOCKED, 0);
        chk("rst_done", oFRAME_DONE, 0);
        chk("rst_syncerr", oSYNC_ERR, 0);
        iRST_n = 1'b1;
        idle(4);

        // Acquire lock: two good frames, writes start with the third.
        send_frame(0, T_VTOTAL, -1, 0, -1);
        send_frame(0, T_VTOTAL, -1, 0, -1);
        chk("unlocked_before_f3", oLOCKED, 0);
        send_frame(0, T_VTOTAL, -1, 2, -1);
        chk("locked_after_f3", oLOCKED, 1);
        chk("no_done_yet", doneCnt, 0);

        // Single lit pixel frame.
        send_frame(1, T_VTOTAL, -1, 2, -1);
        chk("done_f3", doneCnt, 1);

        // Mid-frame reset after the first decimated row.
        send_frame(0, T_VTOTAL, -1, 1, 6);
        chk("done_f4", doneCnt, 2);
        chk("unlocked_after_reset", oLOCKED, 0);
        send_frame(0, T_VTOTAL, -1, 0, -1);
        send_frame(0, T_VTOTAL, -1, 0, -1);
        chk("relock_pending", oLOCKED, 0);
        chk("no_done_reset_frame", doneCnt, 2);
        send_frame(0, T_VTOTAL, -1, 2, -1);
        chk("relocked_after_reset", oLOCKED, 1);

        // Shortened line while locked.
        send_frame(0, T_VTOTAL, 3, 0, -1);
        chk("short_line_err", errCnt, 1);
        chk("short_line_unlock", oLOCKED, 0);
        chk("done_before_short", doneCnt, 3);
        send_frame(0, T_VTOTAL, -1, 0, -1);
        send_frame(0, T_VTOTAL, -1, 0, -1);
        chk("short_relock_pending", oLOCKED, 0);
        send_frame(0, T_VTOTAL, -1, 2, -1);
        chk("short_relocked", oLOCKED, 1);

        // HS held high long enough to saturate hcnt.
        idle(3000);
        chk("hold_no_err_yet", errCnt, 1);
        chk("hold_still_locked", oLOCKED, 1);
        send_frame(0, T_VTOTAL, -1, 0, -1);
        chk("hold_err", errCnt, 2);
        chk("hold_no_done", doneCnt, 3);
        chk("hold_unlock", oLOCKED, 0);
        send_frame(0, T_VTOTAL, -1, 0, -1);
        send_frame(0, T_VTOTAL, -1, 0, -1);
        send_frame(0, T_VTOTAL, -1, 2, -1);
        chk("hold_relocked", oLOCKED, 1);

        // Frame one line short: coincident HS/VS fall with a bad frame length.
        send_frame(0, T_VTOTAL - 1, -1, 2, -1);
        chk("done_before_short_frame", doneCnt, 4);
        send_frame(0, T_VTOTAL, -1, 0, -1);
        chk("short_frame_err", errCnt, 3);
        chk("short_frame_no_done", doneCnt, 4);
        chk("short_frame_unlock", oLOCKED, 0);

        chk("scoreboard_drained", 32'(expAddr.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
